// File: rtl/async_proc_pkg.sv
// Shared constants, state encoding and operand helpers for the async processor
// operand loader.
package async_proc_pkg;

   localparam int NIBBLE_W = 4;
   localparam int NUM_OPS  = 4;
   localparam int IDX_W    = 2;
   localparam int OPS_W    = NIBBLE_W * NUM_OPS;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      GAP,
      SETTLE,
      RESP
   } loader_state_t;

   function automatic logic [NUM_OPS-1:0] strobe_of(input logic [IDX_W-1:0] idx);
      return NUM_OPS'(1) << idx;
   endfunction

   // Lowest set bit wins; scanning downward lets each lower hit overwrite.
   function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_OPS-1:0] m);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = NUM_OPS - 1; i >= 0; i--) begin
         if (m[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [NIBBLE_W-1:0] nibble_of(input logic [OPS_W-1:0] ops,
                                                    input logic [IDX_W-1:0] idx);
      return ops[{idx, 2'b00} +: NIBBLE_W];
   endfunction

endpackage

// File: rtl/async_proc_loader_cycle_timer.sv
// Loadable saturating down-counter shared between the strobe hold and the
// result settle phases; done while the count sits at zero.
module cycle_timer #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign done = (r_count == '0);

endmodule

// File: rtl/async_proc_loader.sv
// Replays up to four operand nibbles onto the processor load bus with one-hot
// strobes, waits for the result to settle and returns it over a response port.
module async_proc_loader
   import async_proc_pkg::*;
#(
   parameter int HOLD_CYCLES   = 1,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [OPS_W-1:0]    req_ops,
   input  logic [NUM_OPS-1:0]  req_mask,
   output logic [7:0]          bus_out,
   input  logic [NIBBLE_W-1:0] result_in,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [NIBBLE_W-1:0] rsp_result,
   output logic                busy
);

   localparam int MAX_CYC = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   // Timer counts load_val..0 inclusive, so a phase of N cycles loads N-1.
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

   loader_state_t        r_state;
   logic [OPS_W-1:0]     r_ops;
   logic [NUM_OPS-1:0]   r_pend;
   logic [7:0]           r_bus;
   logic                 r_req_ready;
   logic                 r_rsp_valid;
   logic [NIBBLE_W-1:0]  r_rsp_result;
   logic                 r_busy;

   logic                 w_accept;
   logic [IDX_W-1:0]     w_first_idx;
   logic [IDX_W-1:0]     w_next_idx;
   logic                 w_tmr_load;
   logic [CNT_W-1:0]     w_tmr_val;
   logic                 w_tmr_done;

   assign w_accept    = req_valid && r_req_ready;
   assign w_first_idx = lowest_set(req_mask);
   assign w_next_idx  = lowest_set(r_pend);

   always_comb begin
      w_tmr_load = 1'b0;
      w_tmr_val  = HOLD_LD;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = (req_mask != '0) ? HOLD_LD : SETTLE_LD;
            end
         end
         WRITE: begin
            if (w_tmr_done && (r_pend == '0)) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = SETTLE_LD;
            end
         end
         GAP: begin
            w_tmr_load = 1'b1;
            w_tmr_val  = HOLD_LD;
         end
         default: ;
      endcase
   end

   cycle_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (w_tmr_load),
      .load_val(w_tmr_val),
      .done    (w_tmr_done)
   );

   // r_pend holds the mask bits not yet written; each write clears its bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_ops        <= '0;
         r_pend       <= '0;
         r_bus        <= 8'h00;
         r_req_ready  <= 1'b1;
         r_rsp_valid  <= 1'b0;
         r_rsp_result <= '0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_ops       <= req_ops;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if (req_mask != '0) begin
                     r_state <= WRITE;
                     r_pend  <= req_mask & ~strobe_of(w_first_idx);
                     r_bus   <= {strobe_of(w_first_idx), nibble_of(req_ops, w_first_idx)};
                  end else begin
                     r_state <= SETTLE;
                     r_pend  <= '0;
                     r_bus   <= 8'h00;
                  end
               end
            end
            WRITE: begin
               if (w_tmr_done) begin
                  if (r_pend != '0) begin
                     r_state <= GAP;
                     r_bus   <= {4'b0000, r_bus[3:0]};
                  end else begin
                     r_state <= SETTLE;
                     r_bus   <= 8'h00;
                  end
               end
            end
            GAP: begin
               r_state <= WRITE;
               r_pend  <= r_pend & ~strobe_of(w_next_idx);
               r_bus   <= {strobe_of(w_next_idx), nibble_of(r_ops, w_next_idx)};
            end
            SETTLE: begin
               if (w_tmr_done) begin
                  r_state      <= RESP;
                  r_rsp_result <= result_in;
                  r_rsp_valid  <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_state     <= IDLE;
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_bus       <= 8'h00;
               r_rsp_valid <= 1'b0;
               r_req_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign bus_out    = r_bus;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_result = r_rsp_result;
   assign busy       = r_busy;

endmodule

// File: tb/tb_async_proc_loader.sv
// Directed bench for the operand loader: default-timing instance plus a
// HOLD_CYCLES=3 instance sharing the request/response inputs.
module tb_async_proc_loader;

   logic        clk;
   logic        rst;
   logic        req_valid_a, req_valid_b;
   logic [15:0] req_ops;
   logic [3:0]  req_mask;
   logic [3:0]  result_in;
   logic        rsp_ready;

   logic       req_ready_a, rsp_valid_a, busy_a;
   logic [7:0] bus_out_a;
   logic [3:0] rsp_result_a;
   logic       req_ready_b, rsp_valid_b, busy_b;
   logic [7:0] bus_out_b;
   logic [3:0] rsp_result_b;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_bus[$];

   async_proc_loader u_dut_a (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_a), .req_ready(req_ready_a),
      .req_ops(req_ops), .req_mask(req_mask),
      .bus_out(bus_out_a), .result_in(result_in),
      .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result_a), .busy(busy_a)
   );

   async_proc_loader #(.HOLD_CYCLES(3), .SETTLE_CYCLES(4)) u_dut_b (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_ops(req_ops), .req_mask(req_mask),
      .bus_out(bus_out_b), .result_in(result_in),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, then walk cycles 1..rsp_cyc checking the bus against
   // exp_bus (zero beyond it). result_in carries res only in the last settle
   // cycle so the capture edge is pinned down.
   task automatic play(input bit sel, input logic [3:0] mask, input logic [15:0] ops,
                       input int rsp_cyc, input logic [3:0] res, input bit ack);
      logic [7:0] e;
      req_mask  = mask;
      req_ops   = ops;
      result_in = ~res;
      if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
      chk("accept_ready", sel ? req_ready_b : req_ready_a, 1);
      step();
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
      for (int c = 1; c <= rsp_cyc; c++) begin
         result_in = (c == rsp_cyc - 1) ? res : ~res;
         e = (c <= exp_bus.size()) ? exp_bus[c-1] : 8'h00;
         chk($sformatf("bus_c%0d", c), sel ? bus_out_b : bus_out_a, e);
         chk($sformatf("rspv_c%0d", c), sel ? rsp_valid_b : rsp_valid_a, (c == rsp_cyc) ? 1 : 0);
         chk($sformatf("busy_c%0d", c), sel ? busy_b : busy_a, 1);
         chk($sformatf("rdy_c%0d", c), sel ? req_ready_b : req_ready_a, 0);
         if (c < rsp_cyc) step();
      end
      chk("rsp_result", sel ? rsp_result_b : rsp_result_a, res);
      if (ack) begin
         rsp_ready = 1'b1;
         step();
         rsp_ready = 1'b0;
         chk("post_ack_ready", sel ? req_ready_b : req_ready_a, 1);
         chk("post_ack_rspv", sel ? rsp_valid_b : rsp_valid_a, 0);
         chk("post_ack_busy", sel ? busy_b : busy_a, 0);
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
      req_ops = '0;
      req_mask = '0;
      result_in = '0;
      rsp_ready = 1'b0;
      #3;
      chk("rst_ready", req_ready_a, 1);
      chk("rst_bus", bus_out_a, 8'h00);
      chk("rst_rspv", rsp_valid_a, 0);
      chk("rst_result", rsp_result_a, 0);
      chk("rst_busy", busy_a, 0);
      step();
      step();
      rst = 1'b0;
      step();

      // full load
      exp_bus = '{8'h11, 8'h01, 8'h22, 8'h02, 8'h43, 8'h03, 8'h84};
      play(1'b0, 4'hF, 16'h4321, 12, 4'hA, 1'b1);

      // sparse load
      exp_bus = '{8'h49};
      play(1'b0, 4'b0100, 16'h0900, 6, 4'h6, 1'b1);

      // empty mask
      exp_bus.delete();
      play(1'b0, 4'h0, 16'hFFFF, 5, 4'h3, 1'b1);

      // backpressure: result held while result_in keeps moving
      exp_bus = '{8'h11, 8'h01, 8'h22, 8'h02, 8'h43, 8'h03, 8'h84};
      play(1'b0, 4'hF, 16'h4321, 12, 4'hA, 1'b0);
      for (int k = 0; k < 3; k++) begin
         result_in = 4'(k + 1);
         step();
         chk($sformatf("bp_result_%0d", k), rsp_result_a, 4'hA);
         chk($sformatf("bp_ready_%0d", k), req_ready_a, 0);
         chk($sformatf("bp_rspv_%0d", k), rsp_valid_a, 1);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("bp_release_ready", req_ready_a, 1);
      chk("bp_release_rspv", rsp_valid_a, 0);

      // reset during the op2 strobe
      req_mask = 4'hF;
      req_ops = 16'h4321;
      req_valid_a = 1'b1;
      step();
      req_valid_a = 1'b0;
      step();
      step();
      chk("mid_op2_bus", bus_out_a, 8'h22);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_bus", bus_out_a, 8'h00);
      chk("mid_rst_busy", busy_a, 0);
      chk("mid_rst_ready", req_ready_a, 1);
      step();
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         chk($sformatf("no_rsp_%0d", k), rsp_valid_a, 0);
      end
      chk("post_rst_bus", bus_out_a, 8'h00);
      play(1'b0, 4'hF, 16'h4321, 12, 4'hA, 1'b1);

      // long hold instance
      exp_bus = '{8'h15, 8'h15, 8'h15, 8'h05, 8'h27, 8'h27, 8'h27};
      play(1'b1, 4'b0011, 16'h0075, 12, 4'hC, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
